// File: rtl/data_mem_access_pkg.sv
// rtl/data_mem_access_pkg.sv - size encodings, FSM states and lane helpers for the data memory stage
package data_mem_access_pkg;

    localparam logic [1:0] SZ_NONE = 2'b00;
    localparam logic [1:0] SZ_WORD = 2'b01;
    localparam logic [1:0] SZ_HALF = 2'b10;
    localparam logic [1:0] SZ_BYTE = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_LOAD_WAIT = 2'b01,
        ST_RMW_MERGE = 2'b10
    } state_t;

    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            SZ_WORD: return (offset == 2'b00);
            SZ_HALF: return (offset[0] == 1'b0);
            default: return 1'b1;
        endcase
    endfunction

    // Little-endian lane pick, always sign-extended to 32 bits.
    function automatic logic [31:0] lane_extract(input logic [31:0] word, input logic [1:0] size,
                                                 input logic [1:0] offset);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{offset, 3'b000} +: 8];
        h = offset[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_WORD: return word;
            SZ_HALF: return {{16{h[15]}}, h};
            SZ_BYTE: return {{24{b[7]}}, b};
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] lane_merge(input logic [31:0] word, input logic [31:0] data,
                                               input logic [1:0] size, input logic [1:0] offset);
        logic [31:0] m;
        m = word;
        case (size)
            SZ_WORD: m = data;
            SZ_HALF: begin
                if (offset[1]) m[31:16] = data[15:0];
                else           m[15:0]  = data[15:0];
            end
            SZ_BYTE: m[{offset, 3'b000} +: 8] = data[7:0];
            default: m = word;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/data_mem_ram.sv
// rtl/data_mem_ram.sv - single-port synchronous word RAM with registered read
module data_mem_ram #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [DEPTH];

    // Read-first: the registered read returns the pre-write contents.
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        rdata <= mem[addr];
    end

endmodule

// File: rtl/data_mem_access.sv
// rtl/data_mem_access.sv - MEM-stage load/store unit with sub-word read-modify-write
module data_mem_access
    import data_mem_access_pkg::*;
#(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [1:0]  MemWrite,
    input  logic [1:0]  MemRead,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    output logic        Stall,
    output logic [31:0] ReadData,
    output logic        Misaligned
);

    state_t state, state_next;

    logic              is_store, is_load, aligned;
    logic [1:0]        op_size, offset;
    logic [ADDR_W-1:0] word_idx;
    logic              ram_we, stall_raw, mis_raw;
    logic [31:0]       ram_wdata, ram_rdata, read_data;
    logic              unused_addr;

    assign is_store    = (MemWrite != SZ_NONE);
    assign is_load     = !is_store && (MemRead != SZ_NONE);
    assign op_size     = is_store ? MemWrite : MemRead;
    assign offset      = Address[1:0];
    assign word_idx    = Address[ADDR_W+1:2];
    assign aligned     = is_aligned(op_size, offset);
    assign unused_addr = ^Address[31:ADDR_W+2];

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (aligned && is_store && op_size != SZ_WORD) state_next = ST_RMW_MERGE;
                else if (aligned && is_load)                   state_next = ST_LOAD_WAIT;
            end
            ST_LOAD_WAIT: state_next = ST_IDLE;
            ST_RMW_MERGE: state_next = ST_IDLE;
            default:      state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        stall_raw = 1'b0;
        mis_raw   = 1'b0;
        ram_we    = 1'b0;
        ram_wdata = WriteData;
        read_data = 32'h0;
        case (state)
            ST_IDLE: begin
                if ((is_store || is_load) && !aligned) mis_raw = 1'b1;
                else if (is_store && op_size == SZ_WORD) ram_we = 1'b1;
                else if (is_store || is_load) stall_raw = 1'b1;
            end
            ST_RMW_MERGE: begin
                ram_we    = 1'b1;
                ram_wdata = lane_merge(ram_rdata, WriteData, MemWrite, offset);
            end
            ST_LOAD_WAIT: read_data = lane_extract(ram_rdata, MemRead, offset);
            default: ;
        endcase
    end

    // Reset masks outputs and writes at once so an aborted RMW leaves memory intact.
    assign Stall      = stall_raw && !Reset;
    assign Misaligned = mis_raw && !Reset;
    assign ReadData   = Reset ? 32'h0 : read_data;

    data_mem_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (Clk),
        .we    (ram_we && !Reset),
        .addr  (word_idx),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_data_mem_access.sv
// tb/tb_data_mem_access.sv - directed table, reset corner cases and randomized model check
module tb_data_mem_access;

    localparam int DEPTH = 1024;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [1:0]  MemWrite = 2'b00;
    logic [1:0]  MemRead = 2'b00;
    logic [31:0] Address = 32'h0;
    logic [31:0] WriteData = 32'h0;
    logic        Stall;
    logic [31:0] ReadData;
    logic        Misaligned;

    int checks = 0;
    int errors = 0;

    logic [31:0] model_mem [16];

    typedef struct {
        logic [1:0]  mw;
        logic [1:0]  mr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_stall;
        logic        exp_mis;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [13];

    data_mem_access #(.DEPTH(DEPTH)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .MemWrite   (MemWrite),
        .MemRead    (MemRead),
        .Address    (Address),
        .WriteData  (WriteData),
        .Stall      (Stall),
        .ReadData   (ReadData),
        .Misaligned (Misaligned)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic run_op(input string name, input logic [1:0] mw, input logic [1:0] mr,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic exp_stall, input logic exp_mis, input logic [31:0] exp_rd);
        @(negedge Clk);
        MemWrite  = mw;
        MemRead   = mr;
        Address   = addr;
        WriteData = wdata;
        #2;
        check({name, ".stall"}, 32'(Stall), 32'(exp_stall));
        check({name, ".mis"}, 32'(Misaligned), 32'(exp_mis));
        check({name, ".rd0"}, ReadData, 32'h0);
        if (exp_stall) begin
            @(negedge Clk);
            #2;
            check({name, ".stall2"}, 32'(Stall), 32'h0);
            check({name, ".mis2"}, 32'(Misaligned), 32'h0);
            check({name, ".rd"}, ReadData, exp_rd);
        end
    endtask

    // Reference: plain shifts and masks on an array of words.
    task automatic model_op(input logic [1:0] mw, input logic [1:0] mr, input logic [31:0] addr,
                            input logic [31:0] wdata, output logic stall, output logic mis,
                            output logic [31:0] rd);
        int unsigned off, idx, size, sh;
        logic [31:0] w, mask, v;
        off  = addr % 4;
        idx  = (addr / 4) % 16;
        size = (mw != 0) ? mw : mr;
        sh   = 8 * off;
        stall = 1'b0;
        mis   = 1'b0;
        rd    = 32'h0;
        if (size == 0) return;
        if ((size == 1 && off != 0) || (size == 2 && off % 2 != 0)) begin
            mis = 1'b1;
            return;
        end
        w = model_mem[idx];
        if (mw != 0) begin
            stall = (size != 1);
            if (size == 1)      model_mem[idx] = wdata;
            else begin
                mask = (size == 2) ? (32'hFFFF << sh) : (32'hFF << sh);
                model_mem[idx] = (w & ~mask) | ((wdata << sh) & mask);
            end
        end else begin
            stall = 1'b1;
            v = w >> sh;
            if (size == 1)      rd = w;
            else if (size == 2) rd = (v & 32'h8000) ? (v | 32'hFFFF0000) : (v & 32'hFFFF);
            else                rd = (v & 32'h80) ? (v | 32'hFFFFFF00) : (v & 32'hFF);
        end
    endtask

    initial begin
        logic [1:0]  mw, mr;
        logic [31:0] addr, wdata, erd;
        logic        est, emis;

        vecs[0]  = '{2'b01, 2'b00, 32'h100, 32'h11223344, 1'b0, 1'b0, 32'h0};
        vecs[1]  = '{2'b00, 2'b01, 32'h100, 32'h0,        1'b1, 1'b0, 32'h11223344};
        vecs[2]  = '{2'b11, 2'b00, 32'h101, 32'hAB,       1'b1, 1'b0, 32'h0};
        vecs[3]  = '{2'b00, 2'b01, 32'h100, 32'h0,        1'b1, 1'b0, 32'h1122AB44};
        vecs[4]  = '{2'b00, 2'b11, 32'h101, 32'h0,        1'b1, 1'b0, 32'hFFFFFFAB};
        vecs[5]  = '{2'b10, 2'b00, 32'h102, 32'h7FFE,     1'b1, 1'b0, 32'h0};
        vecs[6]  = '{2'b00, 2'b10, 32'h102, 32'h0,        1'b1, 1'b0, 32'h00007FFE};
        vecs[7]  = '{2'b00, 2'b01, 32'h100, 32'h0,        1'b1, 1'b0, 32'h7FFEAB44};
        vecs[8]  = '{2'b00, 2'b10, 32'h103, 32'h0,        1'b0, 1'b1, 32'h0};
        vecs[9]  = '{2'b01, 2'b00, 32'h102, 32'h0,        1'b0, 1'b1, 32'h0};
        vecs[10] = '{2'b00, 2'b01, 32'h100, 32'h0,        1'b1, 1'b0, 32'h7FFEAB44};
        vecs[11] = '{2'b01, 2'b01, 32'(DEPTH*4), 32'hDEADBEEF, 1'b0, 1'b0, 32'h0};
        vecs[12] = '{2'b00, 2'b01, 32'h0,   32'h0,        1'b1, 1'b0, 32'hDEADBEEF};

        // Reset state with a load pending on the inputs
        MemRead = 2'b01;
        Address = 32'h100;
        #3;
        check("reset.stall", 32'(Stall), 32'h0);
        check("reset.rd", ReadData, 32'h0);
        check("reset.mis", 32'(Misaligned), 32'h0);
        @(negedge Clk);
        @(negedge Clk);
        Reset   = 1'b0;
        MemRead = 2'b00;

        for (int i = 0; i < 13; i++)
            run_op($sformatf("vec%0d", i), vecs[i].mw, vecs[i].mr, vecs[i].addr, vecs[i].wdata,
                   vecs[i].exp_stall, vecs[i].exp_mis, vecs[i].exp_rd);

        // Reset arriving while in RMW_MERGE
        @(negedge Clk);
        MemWrite  = 2'b11;
        MemRead   = 2'b00;
        Address   = 32'h100;
        WriteData = 32'h55;
        #2;
        check("rmw_rst.stall_before", 32'(Stall), 32'h1);
        @(posedge Clk);
        #1;
        Reset = 1'b1;
        #1;
        check("rmw_rst.stall", 32'(Stall), 32'h0);
        @(negedge Clk);
        Reset    = 1'b0;
        MemWrite = 2'b00;
        run_op("rmw_rst.load", 2'b00, 2'b01, 32'h100, 32'h0, 1'b1, 1'b0, 32'h7FFEAB44);

        // Reset arriving while in LOAD_WAIT
        @(negedge Clk);
        MemRead = 2'b01;
        Address = 32'h100;
        @(posedge Clk);
        #1;
        Reset = 1'b1;
        #1;
        check("load_rst.rd", ReadData, 32'h0);
        check("load_rst.stall", 32'(Stall), 32'h0);
        @(negedge Clk);
        Reset   = 1'b0;
        MemRead = 2'b00;

        // Randomized traffic over words 0..15 with random ignored high address bits
        for (int i = 0; i < 16; i++) begin
            addr = ($urandom & 32'hFFFFF000) | 32'(i * 4);
            wdata = $urandom;
            model_op(2'b01, 2'b00, addr, wdata, est, emis, erd);
            run_op("init", 2'b01, 2'b00, addr, wdata, est, emis, erd);
        end
        for (int i = 0; i < 400; i++) begin
            mw    = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom);
            mr    = 2'($urandom);
            addr  = ($urandom & 32'hFFFFF000) | 32'($urandom_range(0, 63));
            wdata = $urandom;
            model_op(mw, mr, addr, wdata, est, emis, erd);
            run_op($sformatf("rnd%0d", i), mw, mr, addr, wdata, est, emis, erd);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
